// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end constants and types used by the fetch stage.
package riscv_pkg;
  localparam int          XLEN       = 32;
  localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;
  localparam logic [6:0]  OPC_BRANCH = 7'b1100011;

  typedef logic [XLEN-1:0] pc_t;
endpackage

// File: rtl/btfn_predictor.sv
// Backward-taken/forward-not-taken static predictor; only built with FETCH_BTFN_PREDICT_EN.
`ifdef FETCH_BTFN_PREDICT_EN
module btfn_predictor
  import riscv_pkg::*;
(
  input  logic [31:0] instr,
  input  pc_t         pc,
  output logic        pred_taken,
  output pc_t         pred_target
);
  pc_t b_imm;

  // B-type immediate: {imm[12], imm[11], imm[10:5], imm[4:1], 0}, sign-extended from bit 12
  assign b_imm       = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign pred_taken  = (instr[6:0] == OPC_BRANCH) && instr[31];
  assign pred_target = pc + b_imm;
endmodule
`endif

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register and IF/EX pipeline register with stall/redirect/flush.
// Optional static backward-branch prediction enabled by macro FETCH_BTFN_PREDICT_EN.
module fetch_stage
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_instr_o,
  output logic        if_valid_o,
  output logic        if_pred_taken_o
);
  pc_t  pc;
  pc_t  pc_plus4;
  pc_t  next_pc;
  pc_t  redirect_target;
  logic pred_taken;
  pc_t  pred_target;

  assign imem_addr_o     = pc;
  assign pc_plus4        = pc + 32'd4;
  assign redirect_target = redirect_pc_i & ~32'd3;

`ifdef FETCH_BTFN_PREDICT_EN
  logic pred_q;

  btfn_predictor u_btfn_predictor (
    .instr       (imem_rdata_i),
    .pc          (pc),
    .pred_taken  (pred_taken),
    .pred_target (pred_target)
  );

  always_ff @(posedge clk) begin
    if (reset || redirect_i)
      pred_q <= 1'b0;
    else if (!stall_i)
      pred_q <= pred_taken;
  end

  assign if_pred_taken_o = pred_q;
`else
  assign pred_taken      = 1'b0;
  assign pred_target     = pc_plus4;
  assign if_pred_taken_o = 1'b0;
`endif

  // Prediction only reaches the PC on the unstalled, non-redirect path below.
  assign next_pc = pred_taken ? pred_target : pc_plus4;

  always_ff @(posedge clk) begin
    if (reset) begin
      pc         <= RESET_PC;
      if_pc_o    <= '0;
      if_instr_o <= NOP_INSTR;
      if_valid_o <= 1'b0;
    end else if (redirect_i) begin
      pc         <= redirect_target;
      if_pc_o    <= '0;
      if_instr_o <= NOP_INSTR;
      if_valid_o <= 1'b0;
    end else if (!stall_i) begin
      pc         <= next_pc;
      if_pc_o    <= pc;
      if_instr_o <= imem_rdata_i;
      if_valid_o <= 1'b1;
    end
  end
endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage; expectations follow FETCH_BTFN_PREDICT_EN.
module tb_fetch_stage;
  logic        clk = 1'b0;
  logic        reset;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_rdata_i;
  logic [31:0] if_pc_o;
  logic [31:0] if_instr_o;
  logic        if_valid_o;
  logic        if_pred_taken_o;
  logic        br_en;

  int n_chk  = 0;
  int n_fail = 0;

`ifdef FETCH_BTFN_PREDICT_EN
  localparam logic [31:0] EXP_BR_NEXT = 32'h0000_001C;
  localparam logic [31:0] EXP_BR_PRED = 32'd1;
`else
  localparam logic [31:0] EXP_BR_NEXT = 32'h0000_0024;
  localparam logic [31:0] EXP_BR_PRED = 32'd0;
`endif

  always #5 clk = ~clk;

  // imem returns its address as data, except a backward beq at 0x20 when enabled
  assign imem_rdata_i = (br_en && imem_addr_o == 32'h20) ? 32'hFE00_0EE3 : imem_addr_o;

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk             (clk),
    .reset           (reset),
    .stall_i         (stall_i),
    .redirect_i      (redirect_i),
    .redirect_pc_i   (redirect_pc_i),
    .imem_addr_o     (imem_addr_o),
    .imem_rdata_i    (imem_rdata_i),
    .if_pc_o         (if_pc_o),
    .if_instr_o      (if_instr_o),
    .if_valid_o      (if_valid_o),
    .if_pred_taken_o (if_pred_taken_o)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [31:0] pc, input logic [31:0] ins,
                         input logic vld, input logic [31:0] addr);
    chk({tag, ".if_pc"}, if_pc_o, pc);
    chk({tag, ".if_instr"}, if_instr_o, ins);
    chk({tag, ".if_valid"}, {31'd0, if_valid_o}, {31'd0, vld});
    chk({tag, ".imem_addr"}, imem_addr_o, addr);
  endtask

  initial begin
    reset = 1'b1; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0; br_en = 1'b0;

    for (int i = 0; i < 2; i++) begin
      step();
      chk_out("reset", 32'h0, 32'h13, 1'b0, 32'h0);
      chk("reset.pred", {31'd0, if_pred_taken_o}, 32'd0);
    end

    reset = 1'b0;
    step(); chk_out("seq0", 32'h0, 32'h0, 1'b1, 32'h4);
    step(); chk_out("seq1", 32'h4, 32'h4, 1'b1, 32'h8);
    step(); chk_out("seq2", 32'h8, 32'h8, 1'b1, 32'hC);
    step(); chk_out("seq3", 32'hC, 32'hC, 1'b1, 32'h10);

    stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(); chk_out("stall", 32'hC, 32'hC, 1'b1, 32'h10);
    end
    stall_i = 1'b0;
    step(); chk_out("resume", 32'h10, 32'h10, 1'b1, 32'h14);

    redirect_i = 1'b1; redirect_pc_i = 32'h103; stall_i = 1'b1;
    step(); chk_out("redir_stall", 32'h0, 32'h13, 1'b0, 32'h100);
    chk("redir_stall.pred", {31'd0, if_pred_taken_o}, 32'd0);
    redirect_i = 1'b0; stall_i = 1'b0;
    step(); chk_out("redir_first", 32'h100, 32'h100, 1'b1, 32'h104);

    redirect_i = 1'b1; redirect_pc_i = 32'h40;
    step(); chk_out("bubble", 32'h0, 32'h13, 1'b0, 32'h40);
    redirect_i = 1'b0; stall_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step(); chk_out("bubble_hold", 32'h0, 32'h13, 1'b0, 32'h40);
    end
    stall_i = 1'b0;
    step(); chk_out("bubble_end", 32'h40, 32'h40, 1'b1, 32'h44);

    redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFE;
    step(); chk_out("wrap_redir", 32'h0, 32'h13, 1'b0, 32'hFFFF_FFFC);
    redirect_i = 1'b0;
    step(); chk_out("wrap", 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b1, 32'h0);

    br_en = 1'b1; redirect_i = 1'b1; redirect_pc_i = 32'h20;
    step(); chk("br_redir.addr", imem_addr_o, 32'h20);
    redirect_i = 1'b0; stall_i = 1'b1;
    step(); chk("br_stall.addr", imem_addr_o, 32'h20);
    chk("br_stall.pred", {31'd0, if_pred_taken_o}, 32'd0);
    stall_i = 1'b0;
    step(); chk_out("br", 32'h20, 32'hFE00_0EE3, 1'b1, EXP_BR_NEXT);
    chk("br.pred", {31'd0, if_pred_taken_o}, EXP_BR_PRED);
    br_en = 1'b0;

    redirect_i = 1'b1; redirect_pc_i = 32'h200; reset = 1'b1; stall_i = 1'b1;
    step(); chk_out("rst_redir", 32'h0, 32'h13, 1'b0, 32'h0);
    chk("rst_redir.pred", {31'd0, if_pred_taken_o}, 32'd0);
    redirect_i = 1'b0; stall_i = 1'b0; reset = 1'b0;
    step(); chk_out("after_rst", 32'h0, 32'h0, 1'b1, 32'h4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the PC loaded on reset.
REQ-002 Port clk  input  1  SHALL be the single clock; all state updates on rising edge.
REQ-003 Port reset  input  1  SHALL be the reset: synchronous, active-high.
REQ-004 Port stall_i  input  1  SHALL hold PC and IF/EX register when high.
REQ-005 Port redirect_i  input  1  SHALL flag a taken branch/jump or mispredict from execute.
REQ-006 Port redirect_pc_i  input  32  SHALL carry the redirect target.
REQ-007 Port imem_addr_o  output  32  SHALL drive the instruction memory word address, equal to current PC.
REQ-008 Port imem_rdata_i  input  32  SHALL return the instruction at imem_addr_o combinationally, same cycle.
REQ-009 Port if_pc_o  output  32  SHALL present the registered PC of the fetched instruction.
REQ-010 Port if_instr_o  output  32  SHALL present the registered fetched instruction.
REQ-011 Port if_valid_o  output  1  SHALL mark if_instr_o as a real instruction (0 = bubble).
REQ-012 Port if_pred_taken_o  output  1  SHALL flag that fetch predicted this instruction taken.

Function
REQ-013 PC register SHALL update each edge with priority: reset > redirect_i > stall_i > prediction > PC+4.
REQ-014 Normal cycle (no stall, no redirect): IF/EX register SHALL capture {PC, imem_rdata_i, valid=1}; PC SHALL advance; latency fetch-to-output exactly 1 cycle.
REQ-015 stall_i=1, redirect_i=0: PC and all IF/EX outputs SHALL hold their values unchanged.
REQ-016 redirect_i=1 (regardless of stall_i): PC SHALL load {redirect_pc_i[31:2],2'b00}; IF/EX SHALL flush to if_valid_o=0, if_instr_o=NOP 32'h0000_0013, if_pred_taken_o=0, if_pc_o=0.
REQ-017 Redirect target low two bits SHALL be forced to zero; no misalignment exception generated here.
REQ-018 PC+4 arithmetic SHALL be 32-bit modulo: PC 32'hFFFF_FFFC advances to 32'h0000_0000.
REQ-019 First instruction after a redirect SHALL appear on the IF/EX outputs with if_valid_o=1 exactly one edge after the redirect edge, if not stalled.
REQ-020 Bubble state (if_valid_o=0) SHALL persist under stall until the next unstalled edge.

Reset
REQ-021 On reset edge: PC=RESET_PC, if_valid_o=0, if_instr_o=32'h0000_0013, if_pc_o=0, if_pred_taken_o=0.
REQ-022 Reset asserted mid-stall or mid-redirect SHALL override both; first valid fetch follows the first edge with reset low.
REQ-023 imem_addr_o SHALL equal RESET_PC in every cycle reset is high after the first edge.

Configuration
REQ-024 Macro FETCH_BTFN_PREDICT_EN defined: for imem_rdata_i opcode 7'b1100011 with bit31=1 (backward branch), next PC SHALL be PC+sign-extended B-immediate and if_pred_taken_o SHALL be captured as 1.
REQ-025 Macro FETCH_BTFN_PREDICT_EN undefined: next PC SHALL always be PC+4 and if_pred_taken_o SHALL be constant 0.
REQ-026 Prediction SHALL be suppressed in any cycle where redirect_i or stall_i is high.

Structure
REQ-027 Shared package riscv_pkg SHALL hold NOP_INSTR (32'h0000_0013), OPC_BRANCH (7'b1100011), XLEN=32, and typedef pc_t (logic [31:0]).
REQ-028 Sub-module btfn_predictor (combinational: instr, pc -> pred_taken, pred_target) SHALL be instantiated only under FETCH_BTFN_PREDICT_EN.
REQ-029 Block SHALL contain no other sub-modules; imem lives outside.

Verification
REQ-030 Reset 2 cycles, RESET_PC=0, imem returns addr-as-data -> outputs (pc,instr,valid) = (0,0,1),(4,4,1),(8,8,1) on successive edges.
REQ-031 stall_i high for 3 cycles at PC=0x10 -> if_pc_o holds 0x0C, imem_addr_o holds 0x10; resumes 0x10 next edge after release.
REQ-032 redirect_i=1, redirect_pc_i=0x103 with stall_i=1 -> next edge PC=0x100, if_valid_o=0, if_instr_o=0x13; following edge if_pc_o=0x100, valid=1.
REQ-033 PC forced to 0xFFFFFFFC via redirect -> fetch 0xFFFFFFFC then imem_addr_o=0x00000000.
REQ-034 Macro defined, instr 0xFE000EE3 (beq x0,x0,-4) at PC=0x20 -> next PC=0x1C, if_pred_taken_o=1; macro undefined -> next PC=0x24, pred 0.
REQ-035 reset asserted during redirect_i=1 to 0x200 -> PC=RESET_PC, if_valid_o=0.
